// File: rtl/sar_search.sv
// Successive-approximation search controller.
// Drives probe word X into an external magnitude comparator and resolves the
// unknown operand Y MSB first, one probe per clock, using the Zx/Zy/Zeq flags.
module sar_search #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         Zx,
  input  logic         Zy,
  input  logic         Zeq,
  output logic [W-1:0] X,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         found,
  output logic         err
);

  // Bit index needs at least one bit so W=1 still elaborates.
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MSB_PROBE = W'(1) << (W - 1);
  localparam logic [IW-1:0] TOP_IDX  = IW'(W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt, idx_dec;
  logic [W-1:0]  x_nxt, result_nxt, probe;
  logic          found_nxt, err_nxt, flags_ok;

  // A well-behaved comparator asserts exactly one of its three flags.
  function automatic logic onehot3(input logic a, input logic b, input logic c);
    return ({a, b, c} == 3'b100) || ({a, b, c} == 3'b010) || ({a, b, c} == 3'b001);
  endfunction

  assign flags_ok = onehot3(Zx, Zy, Zeq);
  assign idx_dec  = idx - 1'b1;
  assign busy     = (state == PROBE) || (state == VERIFY);
  assign done     = (state == DONE);

  // Next-state and next-register computation; every target defaults to hold.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    x_nxt      = X;
    result_nxt = result;
    found_nxt  = found;
    err_nxt    = err;
    probe      = X;
    case (state)
      IDLE: begin
        x_nxt = '0;
        if (start) begin
          state_nxt  = PROBE;
          x_nxt      = MSB_PROBE;
          idx_nxt    = TOP_IDX;
          result_nxt = '0;
          found_nxt  = 1'b0;
          err_nxt    = 1'b0;
        end
      end
      PROBE: begin
        if (!flags_ok) begin
          err_nxt    = 1'b1;
          found_nxt  = 1'b0;
          result_nxt = X;
          x_nxt      = '0;
          state_nxt  = DONE;
        end else if (Zeq) begin
          // Exact hit: no need to resolve the remaining low bits.
          result_nxt = X;
          found_nxt  = 1'b1;
          x_nxt      = '0;
          state_nxt  = DONE;
        end else begin
          if (Zx) probe[idx] = 1'b0;
          if (idx != '0) begin
            probe[idx_dec] = 1'b1;
            idx_nxt        = idx_dec;
          end else begin
            state_nxt = VERIFY;
          end
          x_nxt = probe;
        end
      end
      VERIFY: begin
        // All bits decided; one last probe confirms the resolved value.
        result_nxt = X;
        if (!flags_ok) begin
          err_nxt   = 1'b1;
          found_nxt = 1'b0;
        end else begin
          found_nxt = Zeq;
        end
        x_nxt     = '0;
        state_nxt = DONE;
      end
      DONE: begin
        x_nxt     = '0;
        state_nxt = IDLE;
      end
      default: begin
        x_nxt     = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any search in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      idx    <= TOP_IDX;
      X      <= '0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      X      <= x_nxt;
      result <= result_nxt;
      found  <= found_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: comparator modelled as X vs Y compare,
// expectations from a lo/hi binary-search reference model.
module tb_sar_search;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic         Zx, Zy, Zeq;
  logic [W-1:0] X, result;
  logic         busy, done, found, err;

  logic [W-1:0] Y;
  logic         force_bad;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] seen[$];
  int           exp_q[$];
  logic         err_c1;

  always #5 CLK = ~CLK;

  assign Zx  = force_bad ? 1'b1 : (X > Y);
  assign Zy  = force_bad ? 1'b1 : (X < Y);
  assign Zeq = force_bad ? 1'b0 : (X == Y);

  sar_search #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .Zx(Zx), .Zy(Zy), .Zeq(Zeq),
    .X(X), .busy(busy), .done(done),
    .result(result), .found(found), .err(err)
  );

  // Reference: interval binary search over [lo, hi); list of probed values.
  function automatic void model_search(input int y);
    int lo, hi, mid;
    lo = 0;
    hi = 1 << W;
    exp_q.delete();
    while (1) begin
      if (hi - lo == 1) begin
        exp_q.push_back(lo);
        break;
      end
      mid = (lo + hi) / 2;
      exp_q.push_back(mid);
      if (mid == y) break;
      if (mid > y) hi = mid;
      else lo = mid;
    end
  endfunction

  // Run one search; cycle 1 is the cycle after start is accepted.
  task automatic do_search(input logic [W-1:0] y, input int chg_c, input logic [W-1:0] newy,
                           input int bad_c, input int hold_c, output int lat);
    int c;
    bit fin;
    Y = y;
    force_bad = 1'b0;
    seen.delete();
    lat = -1;
    @(negedge CLK);
    start = 1'b1;
    c = 0;
    fin = 0;
    while (!fin && c < 30) begin
      @(negedge CLK);
      c++;
      if (c > hold_c) start = 1'b0;
      if (c == chg_c) Y = newy;
      force_bad = (c == bad_c);
      if (c == 1) err_c1 = err;
      if (busy) seen.push_back(X);
      if (done) begin
        lat = c;
        fin = 1;
      end
    end
    force_bad = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within %0d cycles for Y=%0d", c, y);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b0;
    Y = '0;
    force_bad = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (X !== '0)      begin errors++; $display("FAIL reset_X got %0d want 0", X); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if ({found, err} !== 2'b00) begin errors++; $display("FAIL reset_found_err got %b want 00", {found, err}); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    int lat;
    int ys[4] = '{11, 8, 0, 15};
    int lats[4] = '{5, 2, 6, 5};
    for (int n = 0; n < 4; n++) begin
      do_search(W'(ys[n]), 0, '0, 0, 0, lat);
      model_search(ys[n]);
      checks++; if (lat !== lats[n]) begin errors++; $display("FAIL dir_latency Y=%0d got %0d want %0d", ys[n], lat, lats[n]); end
      checks++; if (result !== W'(ys[n])) begin errors++; $display("FAIL dir_result Y=%0d got %0d want %0d", ys[n], result, ys[n]); end
      checks++; if ({found, err} !== 2'b10) begin errors++; $display("FAIL dir_found_err Y=%0d got %b want 10", ys[n], {found, err}); end
      checks++;
      if (seen.size() != exp_q.size()) begin
        errors++; $display("FAIL dir_probe_count Y=%0d got %0d want %0d", ys[n], seen.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++)
          if (int'(seen[i]) != exp_q[i]) begin
            errors++; $display("FAIL dir_probe Y=%0d idx %0d got %0d want %0d", ys[n], i, seen[i], exp_q[i]);
            break;
          end
      end
      if (n == 0) begin
        // Results must hold through DONE and IDLE; done is a single pulse.
        repeat (3) @(negedge CLK);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL hold_done_busy got %b want 00", {done, busy}); end
        checks++; if (X !== '0) begin errors++; $display("FAIL hold_X got %0d want 0", X); end
        checks++; if (result !== 4'd11 || found !== 1'b1) begin errors++; $display("FAIL hold_result got %0d/%b want 11/1", result, found); end
      end
    end
  endtask

  task automatic test_random();
    int lat, y;
    for (int n = 0; n < 24; n++) begin
      y = $urandom_range(0, (1 << W) - 1);
      model_search(y);
      do_search(W'(y), 0, '0, 0, 0, lat);
      checks++; if (lat !== exp_q.size() + 1) begin errors++; $display("FAIL rnd_latency Y=%0d got %0d want %0d", y, lat, exp_q.size() + 1); end
      checks++; if (result !== W'(y) || {found, err} !== 2'b10) begin errors++; $display("FAIL rnd_result Y=%0d got %0d f%b e%b want %0d f1 e0", y, result, found, err, y); end
      checks++;
      if (seen.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd_probe_count Y=%0d got %0d want %0d", y, seen.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++)
          if (int'(seen[i]) != exp_q[i]) begin
            errors++; $display("FAIL rnd_probe Y=%0d idx %0d got %0d want %0d", y, i, seen[i], exp_q[i]);
            break;
          end
      end
    end
  endtask

  task automatic test_y_change();
    int lat;
    // Probes 8,4 against Y=0, then 2,3 and verify 3 against Y=5: no exact match.
    do_search(4'd0, 3, 4'd5, 0, 0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL ychg_latency got %0d want 6", lat); end
    checks++; if (result !== 4'd3) begin errors++; $display("FAIL ychg_result got %0d want 3", result); end
    checks++; if ({found, err} !== 2'b00) begin errors++; $display("FAIL ychg_found_err got %b want 00", {found, err}); end
  endtask

  task automatic test_bad_flags();
    int lat;
    do_search(4'd11, 0, '0, 2, 0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bad_latency got %0d want 3", lat); end
    checks++; if ({err, found} !== 2'b10) begin errors++; $display("FAIL bad_err_found got %b want 10", {err, found}); end
    checks++; if (result !== 4'd12) begin errors++; $display("FAIL bad_result got %0d want 12", result); end
    @(negedge CLK);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL bad_done_pulse got %b want 0", done); end
    do_search(4'd5, 0, '0, 0, 0, lat);
    checks++; if (err_c1 !== 1'b0) begin errors++; $display("FAIL bad_err_cleared got %b want 0", err_c1); end
    checks++; if (result !== 4'd5 || {found, err} !== 2'b10) begin errors++; $display("FAIL bad_recover got %0d f%b e%b want 5 f1 e0", result, found, err); end
  endtask

  task automatic test_reset_mid();
    Y = 4'd0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    #1 RST = 1'b1;
    #1;
    checks++; if ({X, busy, done, result, found, err} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got X%0d b%b d%b r%0d f%b e%b want all 0", X, busy, done, result, found, err);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (busy !== 1'b0 || X !== '0) begin errors++; $display("FAIL rstmid_idle got b%b X%0d want b0 X0", busy, X); end
  endtask

  task automatic test_back_to_back();
    int lat;
    // start held during the search is ignored: timing unchanged.
    do_search(4'd11, 0, '0, 0, 3, lat);
    checks++; if (lat !== 5 || result !== 4'd11) begin errors++; $display("FAIL busy_start got lat%0d r%0d want lat5 r11", lat, result); end
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
    // start held through DONE re-triggers from IDLE on the following cycle.
    do_search(4'd6, 0, '0, 0, 99, lat);
    checks++; if (lat !== 4 || result !== 4'd6) begin errors++; $display("FAIL held_first got lat%0d r%0d want lat4 r6", lat, result); end
    @(negedge CLK);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL held_idle got b%b d%b want b0 d0", busy, done); end
    @(negedge CLK);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || X !== 4'd8 || result !== '0) begin
      errors++; $display("FAIL held_retrigger got b%b X%0d r%0d want b1 X8 r0", busy, X, result);
    end
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    checks++; if (!done || result !== 4'd6 || found !== 1'b1) begin
      errors++; $display("FAIL held_second got d%b r%0d f%b want d1 r6 f1", done, result, found);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_y_change();
    test_bad_flags();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
